mem_issue_arbiter: RTL
======================

// Module: mem_issue_arbiter
// PURPOSE
//   Shares the single memory address pipeline between NREQ memory-op requesters
//   (load RS, store RS, ...). Picks one valid requester per cycle, round-robin,
//   and holds the winning op in a one-entry output register. That register drives
//   the memory pipeline's input port with a valid/ready handshake.
//   Also provides a synchronous flush that kills the buffered op on a mispredict.
// PARAMETERS
//   NREQ   2   number of requesters, 2..8
//   IDW    3   width of grant_id; must satisfy 2**IDW >= NREQ
// PORTS
//   clk            in   1          system clock, all state on posedge
//   rst_n          in   1          asynchronous active-low reset
//   req_valid      in   NREQ       requester i has an op pending
//   req_ready      out  NREQ       requester i's op accepted this cycle (one-hot or 0)
//   req_opcode     in   5*NREQ     per-requester mem opcode; bit0=1 full 16b add, 0 in-page
//   req_base       in   16*NREQ    per-requester base address
//   req_offset     in   8*NREQ     per-requester unsigned offset
//   req_dest       in   5*NREQ     per-requester destination phys reg
//   req_data       in   8*NREQ     per-requester store data
//   req_store      in   NREQ       per-requester store flag
//   flush          in   1          kill buffered op, block grants this cycle
//   mem_opcode     out  5          to memory pipeline
//   base_val       out  16         to memory pipeline
//   offset         out  8          to memory pipeline
//   dest_reg       out  5          to memory pipeline
//   data           out  8          to memory pipeline
//   store          out  1          to memory pipeline
//   grant_id       out  IDW        index of requester whose op is in the slot
//   out_valid      out  1          slot holds a valid op
//   out_ready      in   1          memory pipeline accepts slot this cycle
// BEHAVIOUR
//   Reset (rst_n=0, async): out_valid=0, all op fields=0, grant_id=0, rr_ptr=0.
//     The reset overrides any in-flight transfer. After release, the first grant
//     is the lowest valid index >= 0.
//   slot_free = !out_valid | out_ready (combinational).
//   Winner: first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//   req_ready[w]=1 only when slot_free & !flush & req_valid[w], for winner w;
//     all other bits 0. req_ready is combinational from req_valid/out_ready/flush.
//     req_ready never goes high for a requester whose req_valid is low.
//   Requesters hold valid and fields stable until req_ready; no retraction.
//   Posedge, priority order:
//     1. flush=1: out_valid<=0, fields and grant_id held, rr_ptr held.
//        Any op not yet accepted by the pipeline is dropped.
//     2. Else if slot_free & some req_valid: latch winner's fields, grant_id<=w,
//        out_valid<=1, rr_ptr<=(w+1) mod NREQ.
//     3. Else if slot_free: out_valid<=0, fields held.
//     4. Else (out_valid & !out_ready): slot and rr_ptr fully held.
//   Latency: op accepted at edge N appears at outputs after edge N. Throughput
//     is 1 op/cycle when out_ready=1.
//   Simultaneous drain and refill (out_valid & out_ready & req_valid) is legal,
//     and out_valid stays 1 with no bubble.
//   Fairness: with k requesters continuously valid, each is granted exactly once
//     every k grants. rr_ptr wraps from NREQ-1 to 0.
//   No address arithmetic here; fields pass bit-exact to the pipeline.
// TESTING
//   T1 reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, grant_id=0
//      immediately (before next clk edge); first grant after release goes to
//      lowest valid index.
//   T2 single req: req_valid=01, base=16'h12F0, off=8'h20, out_ready=1 ->
//      req_ready=01; next cycle out_valid=1, base_val=16'h12F0, offset=8'h20,
//      grant_id=0; steady 1 op/cycle.
//   T3 contention: req_valid=11 held 6 cycles, out_ready=1 ->
//      grant_id sequence 0,1,0,1,0,1; req_ready one-hot each cycle.
//   T4 backpressure: slot full, out_ready=0 for 3 cycles -> req_ready=00 and
//      outputs stable all 3 cycles; out_ready=1 -> the cycle after, next winner
//      loaded with no bubble.
//   T5 flush: out_valid=1, req_valid=11, flush=1 -> req_ready=00; next cycle
//      out_valid=0, rr_ptr unchanged; following grant as if no flush occurred.
//   T6 NREQ=3 wrap: req_valid=101 continuous -> grants 0,2,0,2; index 1 raised
//      after a grant to 2 -> sequence continues 0,1,2.

Source files
------------

// File: rtl/mem_issue_arbiter.sv
// mem_issue_arbiter
//   Shares the single memory address pipeline between NREQ memory-op requesters.
//   Each cycle one valid requester is chosen round-robin and its op is loaded into
//   a one-entry output slot. The slot drives the pipeline with a valid/ready
//   handshake. A synchronous flush drops the buffered op and blocks grants.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   IDW   width of grant_id, 2**IDW >= NREQ
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_opcode/base/offset/dest/data/store
//                     per-requester op fields, packed with requester 0 in the LSBs
//   flush             kill the slot contents, no grant this cycle
//   mem_opcode, base_val, offset, dest_reg, data, store
//                     slot contents presented to the memory pipeline
//   grant_id          index of the requester whose op is in the slot
//   out_valid/ready   slot handshake with the memory pipeline
module mem_issue_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [5*NREQ-1:0] req_opcode,
  input  logic [16*NREQ-1:0] req_base,
  input  logic [8*NREQ-1:0] req_offset,
  input  logic [5*NREQ-1:0] req_dest,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_store,
  input  logic              flush,
  output logic [4:0]        mem_opcode,
  output logic [15:0]       base_val,
  output logic [7:0]        offset,
  output logic [4:0]        dest_reg,
  output logic [7:0]        data,
  output logic              store,
  output logic [IDW-1:0]    grant_id,
  output logic              out_valid,
  input  logic              out_ready
);

  // One extra bit so rr_ptr + k never overflows before the modulo fold.
  localparam int unsigned PW = IDW + 1;
  localparam logic [PW-1:0] NreqP = PW'(NREQ);
  localparam logic [IDW-1:0] LastId = IDW'(NREQ - 1);

  // Slot state.
  logic           out_valid_q, out_valid_d;
  logic [4:0]     opcode_q, opcode_d;
  logic [15:0]    base_q, base_d;
  logic [7:0]     offset_q, offset_d;
  logic [4:0]     dest_q, dest_d;
  logic [7:0]     data_q, data_d;
  logic           store_q, store_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  // Arbitration.
  logic           slot_free;
  logic           grant_fire;
  logic           any_valid;
  logic [IDW-1:0] win_id;
  logic [PW-1:0]  scan_idx;

  // Winner's fields.
  logic [4:0]     sel_opcode;
  logic [15:0]    sel_base;
  logic [7:0]     sel_offset;
  logic [4:0]     sel_dest;
  logic [7:0]     sel_data;
  logic           sel_store;

  assign slot_free  = !out_valid_q || out_ready;
  assign grant_fire = slot_free && !flush && any_valid;

  // Round-robin scan: visit rr_ptr, rr_ptr+1, ... (mod NREQ) and take the
  // first valid requester.
  always_comb begin
    any_valid = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      scan_idx = {1'b0, rr_ptr_q} + PW'(k);
      if (scan_idx >= NreqP) begin
        scan_idx = scan_idx - NreqP;
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!any_valid && req_valid[i] && (scan_idx == PW'(i))) begin
          any_valid = 1'b1;
          win_id    = IDW'(i);
        end
      end
    end
  end

  // Field mux for the winning requester.
  always_comb begin
    sel_opcode = '0;
    sel_base   = '0;
    sel_offset = '0;
    sel_dest   = '0;
    sel_data   = '0;
    sel_store  = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win_id == IDW'(i)) begin
        sel_opcode = req_opcode[i*5 +: 5];
        sel_base   = req_base[i*16 +: 16];
        sel_offset = req_offset[i*8 +: 8];
        sel_dest   = req_dest[i*5 +: 5];
        sel_data   = req_data[i*8 +: 8];
        sel_store  = req_store[i];
      end
    end
  end

  // Accept strobe back to the winner only; grant_fire already implies a valid winner.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_ready[i] = grant_fire && (win_id == IDW'(i));
    end
  end

  // Slot next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    base_d      = base_q;
    offset_d    = offset_q;
    dest_d      = dest_q;
    data_d      = data_q;
    store_d     = store_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush) begin
      // Drop the op; fields and pointer keep their values.
      out_valid_d = 1'b0;
    end else if (slot_free && any_valid) begin
      out_valid_d = 1'b1;
      opcode_d    = sel_opcode;
      base_d      = sel_base;
      offset_d    = sel_offset;
      dest_d      = sel_dest;
      data_d      = sel_data;
      store_d     = sel_store;
      grant_d     = win_id;
      rr_ptr_d    = (win_id == LastId) ? '0 : win_id + 1'b1;
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      base_q      <= '0;
      offset_q    <= '0;
      dest_q      <= '0;
      data_q      <= '0;
      store_q     <= 1'b0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      base_q      <= base_d;
      offset_q    <= offset_d;
      dest_q      <= dest_d;
      data_q      <= data_d;
      store_q     <= store_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign mem_opcode = opcode_q;
  assign base_val   = base_q;
  assign offset     = offset_q;
  assign dest_reg   = dest_q;
  assign data       = data_q;
  assign store      = store_q;
  assign grant_id   = grant_q;

endmodule
